// File: rtl/student_id_scroller.sv
// Scrolls a 4-digit window across a packed BCD student ID.
// Time-multiplexes the window onto a common-anode 4-digit display.
module student_id_scroller #(
  parameter int          ID_DIGITS   = 8,
  parameter logic [31:0] ID_VALUE    = 32'h4107_2035,
  parameter int          REFRESH_DIV = 50000,
  parameter int          SCROLL_DIV  = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       step,
  output logic [3:0] digit_out,
  output logic [3:0] an_out,
  output logic [2:0] start_out,
  output logic       wrap
);

  localparam int RW =
    (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SW =
    (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [RW-1:0] R_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] S_LAST = SW'(SCROLL_DIV - 1);
  localparam logic [2:0] D_LAST = 3'(ID_DIGITS - 1);

  logic [RW-1:0] refresh_cnt;
  logic [SW-1:0] scroll_cnt;
  logic [1:0]    scan;
  logic [2:0]    start;
  logic          tick;
  logic          adv;

  assign tick = (refresh_cnt == R_LAST);
  // manual step only counts while auto-scroll is off
  assign adv  = en ? (scroll_cnt == S_LAST) : step;

  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt <= '0;
      scroll_cnt  <= '0;
      scan        <= '0;
      start       <= '0;
      wrap        <= 1'b0;
    end else begin
      if (tick) begin
        refresh_cnt <= '0;
        scan        <= scan + 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + RW'(1);
      end
      if (en) begin
        if (scroll_cnt == S_LAST)
          scroll_cnt <= '0;
        else
          scroll_cnt <= scroll_cnt + SW'(1);
      end
      if (adv) begin
        if (start == D_LAST)
          start <= '0;
        else
          start <= start + 3'd1;
      end
      wrap <= adv && (start == D_LAST);
    end
  end

  logic [3:0] sum;
  logic [2:0] idx;
  logic [2:0] pos;

  // circular window: wrap index back into the ID
  assign sum = {1'b0, start} + {2'b00, scan};
  assign idx = (sum >= 4'(ID_DIGITS))
             ? 3'(sum - 4'(ID_DIGITS))
             : sum[2:0];
  assign pos = D_LAST - idx;

  assign digit_out = ID_VALUE[{pos, 2'b00} +: 4];
  assign an_out    = ~(4'b1000 >> scan);
  assign start_out = start;

endmodule
